// File: rtl/mac_tile_mc.sv
// Multi-channel systolic MAC tile: one west-to-east activation shared by CH weight/psum lanes.
// Supports weight-stationary and output-stationary operation, including the OS drain chain.
module mac_tile_mc #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int CH      = 2,
  parameter int SAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [bw-1:0]         in_w,
  output logic [bw-1:0]         out_e,
  input  logic [1:0]            inst_w,
  output logic [1:0]            inst_e,
  input  logic [CH*psum_bw-1:0] in_n,
  output logic [CH*psum_bw-1:0] out_s,
  input  logic                  mode_select,
  input  logic                  output_en,
  input  logic                  rearm,
  output logic                  load_done
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [0:0] LOAD  = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic signed [bw-1:0] a_q;
  logic [1:0]           inst_q;
  logic [CW-1:0]        cnt;
  logic [0:0]           state;

  // Qualified control strobes; rearm pre-empts every other action.
  logic ws_active;
  logic load_beat;
  logic os_clear;
  logic os_drain;
  logic os_acc;

  always_comb begin
    ws_active = !rearm && !mode_select && (inst_w != 2'b00);
    load_beat = ws_active && inst_w[0] && (state == LOAD);
    os_clear  = rearm && mode_select;
    os_drain  = !rearm && mode_select && output_en;
    os_acc    = !rearm && mode_select && !output_en && inst_w[1];
  end

  assign out_e     = a_q;
  assign inst_e    = inst_q;
  assign load_done = (state == READY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      inst_q <= 2'b00;
      cnt    <= '0;
      state  <= LOAD;
    end else begin
      inst_q[1] <= inst_w[1];
      inst_q[0] <= (!rearm && (state == READY)) ? inst_w[0] : 1'b0;

      if (rearm) begin
        cnt   <= '0;
        state <= LOAD;
        if (mode_select) begin
          a_q <= '0;
        end
      end else if (os_drain) begin
        a_q <= '0;
      end else if (os_acc || ws_active) begin
        a_q <= in_w;
      end

      if (load_beat) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(CH - 1)) begin
          state <= READY;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      logic signed [bw-1:0]        b_q;
      logic signed [psum_bw-1:0]   c_q;
      logic signed [2*bw-1:0]      prod;
      logic signed [psum_bw:0]     sum;
      logic        [psum_bw-1:0]   m_k;
      logic        [psum_bw-1:0]   n_k;

      assign n_k  = in_n[gi*psum_bw +: psum_bw];
      assign prod = a_q * b_q;
      // One guard bit makes the overflow test a simple sign-bit comparison.
      assign sum  = $signed({c_q[psum_bw-1], c_q})
                  + $signed({{(psum_bw + 1 - 2*bw){prod[2*bw-1]}}, prod});

      if (SAT != 0) begin : g_sat
        always_comb begin
          m_k = sum[psum_bw-1:0];
          if (sum[psum_bw] != sum[psum_bw-1]) begin
            m_k = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                               : {1'b0, {(psum_bw-1){1'b1}}};
          end
        end
      end else begin : g_wrap
        assign m_k = sum[psum_bw-1:0];
      end

      // In OS accumulate the stationary weight is forwarded south instead of the sum.
      assign out_s[gi*psum_bw +: psum_bw] =
        (mode_select && !output_en) ? {{(psum_bw-bw){b_q[bw-1]}}, b_q} : m_k;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          b_q <= '0;
          c_q <= '0;
        end else if (os_clear) begin
          b_q <= '0;
          c_q <= '0;
        end else if (rearm) begin
          b_q <= b_q;
          c_q <= c_q;
        end else if (os_drain) begin
          b_q <= '0;
          c_q <= n_k;
        end else if (os_acc) begin
          b_q <= n_k[bw-1:0];
          c_q <= m_k;
        end else if (ws_active) begin
          if (inst_w[1]) begin
            c_q <= n_k;
          end
          if (load_beat && (cnt == CW'(gi))) begin
            b_q <= in_w;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mac_tile_mc.sv
// Directed testbench for mac_tile_mc: a saturating and a wrapping tile share one stimulus stream.
module tb_mac_tile_mc;
  logic        clk;
  logic        reset;
  logic [3:0]  in_w;
  logic [1:0]  inst_w;
  logic [31:0] in_n;
  logic        mode_select;
  logic        output_en;
  logic        rearm;

  logic [3:0]  out_e,  out_e_w;
  logic [1:0]  inst_e, inst_e_w;
  logic [31:0] out_s,  out_s_w;
  logic        load_done, load_done_w;

  int checks = 0;
  int errors = 0;

  mac_tile_mc #(.bw(4), .psum_bw(16), .CH(2), .SAT(1)) dut (
    .clk(clk), .reset(reset), .in_w(in_w), .out_e(out_e), .inst_w(inst_w),
    .inst_e(inst_e), .in_n(in_n), .out_s(out_s), .mode_select(mode_select),
    .output_en(output_en), .rearm(rearm), .load_done(load_done)
  );

  mac_tile_mc #(.bw(4), .psum_bw(16), .CH(2), .SAT(0)) dut_w (
    .clk(clk), .reset(reset), .in_w(in_w), .out_e(out_e_w), .inst_w(inst_w),
    .inst_e(inst_e_w), .in_n(in_n), .out_s(out_s_w), .mode_select(mode_select),
    .output_en(output_en), .rearm(rearm), .load_done(load_done_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_w = 4'($urandom); inst_w = 2'($urandom); in_n = $urandom;
      mode_select = 1'($urandom); output_en = 1'($urandom); rearm = 1'($urandom);
      tick();
      checks++;
      if (out_e !== 4'h0 || inst_e !== 2'b00 || out_s !== 32'h0 || load_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: out_e=%h inst_e=%b out_s=%h load_done=%b, expected all 0",
                 i, out_e, inst_e, out_s, load_done);
      end
    end
    inst_w = 2'b00; mode_select = 1'b0; output_en = 1'b0; rearm = 1'b0;
    in_w = 4'($urandom); in_n = $urandom;
    reset = 1'b1;
    tick();
    checks++;
    if (out_e !== 4'h0 || inst_e !== 2'b00 || out_s !== 32'h0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: out_e=%h inst_e=%b out_s=%h load_done=%b, expected all 0",
               out_e, inst_e, out_s, load_done);
    end
    $display("test_reset done");
  endtask

  task automatic test_ws_load();
    logic [3:0] vals [3];
    logic       exp_ld [3];
    logic [1:0] exp_ie [3];
    vals   = '{4'd3, 4'hE, 4'd5};
    exp_ld = '{1'b0, 1'b1, 1'b1};
    exp_ie = '{2'b00, 2'b00, 2'b01};
    in_n = 32'h0;
    for (int i = 0; i < 3; i++) begin
      inst_w = 2'b01; in_w = vals[i];
      tick();
      checks++;
      if (out_e !== vals[i] || load_done !== exp_ld[i] || inst_e !== exp_ie[i]) begin
        errors++;
        $display("FAIL ws_load beat=%0d: out_e=%h load_done=%b inst_e=%b, expected %h %b %b",
                 i, out_e, load_done, inst_e, vals[i], exp_ld[i], exp_ie[i]);
      end
      $display("ws_load beat %0d in_w=%h load_done=%b", i, vals[i], load_done);
    end
    inst_w = 2'b00;
  endtask

  task automatic test_ws_execute();
    inst_w = 2'b10; in_w = 4'd4; in_n = {16'(-7), 16'd100};
    tick();
    checks++;
    if (out_s[15:0] !== 16'd112 || out_s[31:16] !== 16'(-15) || out_e !== 4'd4 || inst_e !== 2'b10) begin
      errors++;
      $display("FAIL ws_execute: out_s=%h out_e=%h inst_e=%b, expected fff1_0070 4 10",
               out_s, out_e, inst_e);
    end
    inst_w = 2'b00; in_n = 32'h0;
    tick();
    checks++;
    if (out_s !== {16'(-15), 16'd112} || inst_e !== 2'b00) begin
      errors++;
      $display("FAIL ws_idle_hold: out_s=%h inst_e=%b, expected fff10070 00", out_s, inst_e);
    end
    $display("test_ws_execute out_s=%h", out_s);
  endtask

  task automatic test_saturation();
    rearm = 1'b1; inst_w = 2'b00;
    tick();
    rearm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inst_w = 2'b01; in_w = 4'd3;
      tick();
    end
    checks++;
    if (load_done !== 1'b1 || load_done_w !== 1'b1) begin
      errors++;
      $display("FAIL sat_reload: load_done=%b/%b, expected 1/1", load_done, load_done_w);
    end
    inst_w = 2'b10; in_w = 4'd7; in_n = {16'd0, 16'd32760};
    tick();
    checks++;
    if (out_s[15:0] !== 16'h7FFF || out_s[31:16] !== 16'd21) begin
      errors++;
      $display("FAIL sat_pos: out_s=%h, expected 0015_7fff", out_s);
    end
    checks++;
    if (out_s_w[15:0] !== 16'(-32755)) begin
      errors++;
      $display("FAIL wrap_pos: out_s lane0=%h, expected 800d", out_s_w[15:0]);
    end
    in_w = 4'(-7); in_n = {16'd0, 16'(-32760)};
    tick();
    checks++;
    if (out_s[15:0] !== 16'h8000 || out_s[31:16] !== 16'(-21)) begin
      errors++;
      $display("FAIL sat_neg: out_s=%h, expected ffeb_8000", out_s);
    end
    checks++;
    if (out_s_w[15:0] !== 16'd32755) begin
      errors++;
      $display("FAIL wrap_neg: out_s lane0=%h, expected 7ff3", out_s_w[15:0]);
    end
    inst_w = 2'b00; in_n = 32'h0;
    tick();
    $display("test_saturation done");
  endtask

  task automatic test_os_drain();
    logic [3:0] a_v [3];
    logic [3:0] w_v [3];
    a_v = '{4'd1, 4'd2, 4'hF};
    w_v = '{4'd2, 4'd3, 4'd4};
    mode_select = 1'b1; rearm = 1'b1;
    tick();
    rearm = 1'b0;
    checks++;
    if (out_s !== 32'h0 || out_e !== 4'h0) begin
      errors++;
      $display("FAIL os_clear: out_s=%h out_e=%h, expected 0 0", out_s, out_e);
    end
    for (int i = 0; i < 3; i++) begin
      inst_w = 2'b10; in_w = a_v[i]; in_n = {16'd1, 12'd0, w_v[i]};
      tick();
      checks++;
      if (out_s !== {16'd1, {12{w_v[i][3]}}, w_v[i]}) begin
        errors++;
        $display("FAIL os_weight_fwd beat=%0d: out_s=%h, expected weights %h/1", i, out_s, w_v[i]);
      end
    end
    inst_w = 2'b00; output_en = 1'b1; in_n = {16'(-3), 16'd55};
    #1;
    checks++;
    if (out_s[15:0] !== 16'd4 || out_s[31:16] !== 16'd2) begin
      errors++;
      $display("FAIL os_drain_first: out_s=%h, expected 0002_0004", out_s);
    end
    tick();
    checks++;
    if (out_s[15:0] !== 16'd55 || out_s[31:16] !== 16'(-3)) begin
      errors++;
      $display("FAIL os_drain_shift: out_s=%h, expected fffd_0037", out_s);
    end
    output_en = 1'b0; in_n = 32'h0;
    tick();
    mode_select = 1'b0;
    $display("test_os_drain done");
  endtask

  task automatic test_rearm();
    rearm = 1'b1; inst_w = 2'b00;
    tick();
    rearm = 1'b0;
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL rearm_ws: load_done=%b, expected 0", load_done);
    end
    inst_w = 2'b01; in_w = 4'd6;
    tick();
    rearm = 1'b1; inst_w = 2'b01; in_w = 4'd9;
    tick();
    rearm = 1'b0;
    checks++;
    if (load_done !== 1'b0 || inst_e !== 2'b00) begin
      errors++;
      $display("FAIL rearm_beat_ignored: load_done=%b inst_e=%b, expected 0 00", load_done, inst_e);
    end
    inst_w = 2'b01; in_w = 4'd1;
    tick();
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL rearm_reload1: load_done=%b, expected 0", load_done);
    end
    in_w = 4'd2;
    tick();
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL rearm_reload2: load_done=%b, expected 1", load_done);
    end
    inst_w = 2'b10; in_w = 4'd1; in_n = 32'h0;
    tick();
    checks++;
    if (out_s[15:0] !== 16'd1 || out_s[31:16] !== 16'd2) begin
      errors++;
      $display("FAIL rearm_weights: out_s=%h, expected 0002_0001", out_s);
    end
    inst_w = 2'b00;
    $display("test_rearm done");
  endtask

  initial begin
    reset = 1'b0; in_w = '0; inst_w = '0; in_n = '0;
    mode_select = 1'b0; output_en = 1'b0; rearm = 1'b0;
    test_reset();
    test_ws_load();
    test_ws_execute();
    test_saturation();
    test_os_drain();
    test_rearm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
